// File: rtl/f32_to_i32.sv
// f32_to_i32: iterative IEEE-754 single -> signed int32 converter, one alignment shift per clock.
// Define F32_TO_I32_ROUND_NEAREST_EN for round-to-nearest-even; default build truncates toward zero.
module f32_to_i32 #(
  parameter int WIDTH         = 32,
  parameter int EXPONENTWIDTH = 8,
  parameter int MANTISSAWIDTH = 23
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             inexact
);

  localparam int BIAS = (1 << (EXPONENTWIDTH - 1)) - 1;
  localparam int CNTW = $clog2(MANTISSAWIDTH + 1);
  localparam logic [EXPONENTWIDTH-1:0] EXP_BIAS  = EXPONENTWIDTH'(BIAS);
  localparam logic [EXPONENTWIDTH-1:0] EXP_ALIGN = EXPONENTWIDTH'(BIAS + MANTISSAWIDTH);
  localparam logic [EXPONENTWIDTH-1:0] EXP_SAT   = EXPONENTWIDTH'(BIAS + WIDTH - 1);
  localparam logic [WIDTH-1:0] INT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  // IDLE accept | SHIFT align one bit/clk | FIN round+sign+register | DONE hold until out_ready
  typedef enum logic [1:0] {IDLE, SHIFT, FIN, DONE} state_t;

  state_t                     state_q, state_d;
  logic                       sign_q, sign_d;
  logic [WIDTH-1:0]           mag_q, mag_d;
  logic [CNTW-1:0]            cnt_q, cnt_d;
  logic                       shl_q, shl_d;
  logic                       guard_q, guard_d;
  logic                       sticky_q, sticky_d;
  logic                       spec_q, spec_d;
  logic                       spec_ovf_q, spec_ovf_d;
  logic                       spec_inx_q, spec_inx_d;
  logic [WIDTH-1:0]           res_q, res_d;
  logic                       ovf_q, ovf_d;
  logic                       inx_q, inx_d;

  logic                       a_sign;
  logic [EXPONENTWIDTH-1:0]   a_exp;
  logic [MANTISSAWIDTH-1:0]   a_mant;
  logic                       a_spec, a_ovf, a_inx, a_shl;
  logic [WIDTH-1:0]           a_res;
  logic [CNTW-1:0]            a_k;
  logic [WIDTH-1:0]           mag_rnd;

  assign a_sign = a[WIDTH-1];
  assign a_exp  = a[WIDTH-2 -: EXPONENTWIDTH];
  assign a_mant = a[MANTISSAWIDTH-1:0];

  // Classify the incoming word; special results are fully resolved here, sign included.
  always_comb begin
    a_spec = 1'b1;
    a_ovf  = 1'b0;
    a_inx  = 1'b0;
    a_res  = '0;
    a_shl  = 1'b0;
    a_k    = '0;
    if (a_exp == '0) begin
      a_inx = |a_mant;
    end else if (a_exp == '1) begin
      a_ovf = 1'b1;
      a_inx = 1'b1;
      a_res = (a_sign && a_mant == '0) ? INT_MIN : INT_MAX;
    end else if (a_exp < EXP_BIAS) begin
      a_inx = 1'b1;
`ifdef F32_TO_I32_ROUND_NEAREST_EN
      if (a_exp == EXPONENTWIDTH'(BIAS - 1) && a_mant != '0)
        a_res = a_sign ? '1 : WIDTH'(1);
`endif
    end else if (a_exp > EXP_SAT || (a_exp == EXP_SAT && !(a_sign && a_mant == '0))) begin
      a_ovf = 1'b1;
      a_inx = 1'b1;
      a_res = a_sign ? INT_MIN : INT_MAX;
    end else if (a_exp == EXP_SAT) begin
      a_res = INT_MIN;
    end else begin
      a_spec = 1'b0;
      if (a_exp > EXP_ALIGN) begin
        a_shl = 1'b1;
        a_k   = CNTW'(a_exp - EXP_ALIGN);
      end else begin
        a_k   = CNTW'(EXP_ALIGN - a_exp);
      end
    end
  end

  always_comb begin
    mag_rnd = mag_q;
`ifdef F32_TO_I32_ROUND_NEAREST_EN
    mag_rnd = mag_q + WIDTH'(guard_q & (sticky_q | mag_q[0]));
`endif
  end

  always_comb begin
    state_d    = state_q;
    sign_d     = sign_q;
    mag_d      = mag_q;
    cnt_d      = cnt_q;
    shl_d      = shl_q;
    guard_d    = guard_q;
    sticky_d   = sticky_q;
    spec_d     = spec_q;
    spec_ovf_d = spec_ovf_q;
    spec_inx_d = spec_inx_q;
    res_d      = res_q;
    ovf_d      = ovf_q;
    inx_d      = inx_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d     = a_sign;
          mag_d      = a_spec ? a_res : {{(WIDTH-MANTISSAWIDTH-1){1'b0}}, 1'b1, a_mant};
          cnt_d      = a_k;
          shl_d      = a_shl;
          guard_d    = 1'b0;
          sticky_d   = 1'b0;
          spec_d     = a_spec;
          spec_ovf_d = a_ovf;
          spec_inx_d = a_inx;
          state_d    = (a_spec || a_k == '0) ? FIN : SHIFT;
        end
      end
      SHIFT: begin
        if (shl_q) begin
          mag_d = mag_q << 1;
        end else begin
          mag_d    = mag_q >> 1;
          guard_d  = mag_q[0];
          sticky_d = sticky_q | guard_q;
        end
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNTW'(1)) state_d = FIN;
      end
      FIN: begin
        if (spec_q) begin
          res_d = mag_q;
          ovf_d = spec_ovf_q;
          inx_d = spec_inx_q;
        end else begin
          res_d = sign_q ? -mag_rnd : mag_rnd;
          ovf_d = 1'b0;
          inx_d = guard_q | sticky_q;
        end
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      sign_q     <= 1'b0;
      mag_q      <= '0;
      cnt_q      <= '0;
      shl_q      <= 1'b0;
      guard_q    <= 1'b0;
      sticky_q   <= 1'b0;
      spec_q     <= 1'b0;
      spec_ovf_q <= 1'b0;
      spec_inx_q <= 1'b0;
      res_q      <= '0;
      ovf_q      <= 1'b0;
      inx_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sign_q     <= sign_d;
      mag_q      <= mag_d;
      cnt_q      <= cnt_d;
      shl_q      <= shl_d;
      guard_q    <= guard_d;
      sticky_q   <= sticky_d;
      spec_q     <= spec_d;
      spec_ovf_q <= spec_ovf_d;
      spec_inx_q <= spec_inx_d;
      res_q      <= res_d;
      ovf_q      <= ovf_d;
      inx_q      <= inx_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = res_q;
  assign overflow  = ovf_q;
  assign inexact   = inx_q;

endmodule

// File: tb/tb_f32_to_i32.sv
// Self-checking bench for f32_to_i32: arithmetic reference model plus directed literal vectors.
module tb_f32_to_i32;

`ifdef F32_TO_I32_ROUND_NEAREST_EN
  localparam bit RNE = 1'b1;
`else
  localparam bit RNE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        overflow;
  logic        inexact;

  f32_to_i32 dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .overflow(overflow), .inexact(inexact)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        ovf;
    logic        inx;
    int          lat;
    int          acc;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  bit          cur_seen = 0;
  logic [31:0] last_res = '0;
  logic        last_ovf = 1'b0;
  logic        last_inx = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: value = 1.mant * 2^(exp-150), rounded/truncated on the full remainder.
  function automatic void model(input logic [31:0] x, output logic [31:0] r,
                                output logic ovf, output logic inx, output int lat);
    logic        s;
    int          e, rs;
    logic [63:0] full, mag, rem, half;
    s = x[31];
    e = int'(x[30:23]);
    full = {40'd0, 1'b1, x[22:0]};
    mag = '0; rem = '0; half = '1;
    ovf = 1'b0; inx = 1'b0; lat = 1; r = '0;
    if (e == 255) begin
      ovf = 1'b1; inx = 1'b1;
      r = (x[22:0] != 0 || !s) ? 32'h7FFFFFFF : 32'h80000000;
    end else if (e == 0) begin
      inx = (x[22:0] != 0);
    end else if (e >= 158) begin
      if (s && e == 158 && x[22:0] == 0) r = 32'h80000000;
      else begin
        ovf = 1'b1; inx = 1'b1;
        r = s ? 32'h80000000 : 32'h7FFFFFFF;
      end
    end else begin
      if (e >= 127) lat = ((e > 150) ? e - 150 : 150 - e) + 1;
      if (e >= 150) begin
        mag = full << (e - 150);
      end else begin
        rs = 150 - e;
        if (rs > 40) begin
          rem = full;
        end else begin
          mag  = full >> rs;
          rem  = full & ((64'd1 << rs) - 64'd1);
          half = 64'd1 << (rs - 1);
        end
        inx = (rem != 0);
        if (RNE && (rem > half || (rem == half && mag[0]))) mag = mag + 64'd1;
      end
      r = s ? -mag[31:0] : mag[31:0];
    end
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (in_valid && in_ready) begin
        model(a, e.res, e.ovf, e.inx, e.lat);
        e.acc = cyc + 1;
        q.push_back(e);
      end
      if (out_valid) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL spurious_out_valid actual=%h required=no output", result);
        end else begin
          chk("result", result, q[0].res);
          chk("overflow", {31'd0, overflow}, {31'd0, q[0].ovf});
          chk("inexact", {31'd0, inexact}, {31'd0, q[0].inx});
          chk("in_ready_in_done", {31'd0, in_ready}, 32'd0);
          if (!cur_seen) begin
            chk("latency", cyc - q[0].acc, q[0].lat);
            cur_seen = 1;
          end
          last_res = result; last_ovf = overflow; last_inx = inexact;
          if (out_ready) begin
            void'(q.pop_front());
            cur_seen = 0;
          end
        end
      end
    end
  end

  task automatic send(input logic [31:0] x, input logic ordy);
    int n = 0;
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    if (!in_ready) chk("in_ready_timeout", {31'd0, in_ready}, 32'd1);
    a = x; in_valid = 1'b1; out_ready = ordy;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (q.size() != 0 && n < 200) begin @(posedge clk); #1; n++; end
    chk("done_timeout", q.size(), 0);
  endtask

  task automatic run(input logic [31:0] x, input logic [31:0] r, input logic o, input logic i);
    logic [31:0] mr; logic mo, mi; int ml;
    model(x, mr, mo, mi, ml);
    chk("model_result", mr, r);
    send(x, 1'b1);
    wait_done();
    chk("lit_result", last_res, r);
    chk("lit_overflow", {31'd0, last_ovf}, {31'd0, o});
    chk("lit_inexact", {31'd0, last_inx}, {31'd0, i});
  endtask

  initial begin
    int n;
    logic [31:0] mr; logic mo, mi; int ml;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0;
    #12;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    chk("rst_inexact", {31'd0, inexact}, 32'd0);
    @(posedge clk); #1; rst = 1'b0;

    model(32'h3FE00000, mr, mo, mi, ml);   chk("model_lat_1p75", ml, 24);
    model(32'hC4856B61, mr, mo, mi, ml);   chk("model_lat_m1067", ml, 14);
    model(32'hCF000000, mr, mo, mi, ml);   chk("model_ovf_min", {31'd0, mo}, 32'd0);

    run(32'h3FE00000, RNE ? 32'd2 : 32'd1, 1'b0, 1'b1);
    run(32'hC4856B61, 32'hFFFFFBD5, 1'b0, 1'b1);
    run(32'h4B000000, 32'h00800000, 1'b0, 1'b0);
    run(32'h4FA3739B, 32'h7FFFFFFF, 1'b1, 1'b1);
    run(32'hCF000000, 32'h80000000, 1'b0, 1'b0);
    run(32'h7FC00000, 32'h7FFFFFFF, 1'b1, 1'b1);
    run(32'hFFC00000, 32'h7FFFFFFF, 1'b1, 1'b1);
    run(32'h00000000, 32'h00000000, 1'b0, 1'b0);
    run(32'h00000001, 32'h00000000, 1'b0, 1'b1);
    run(32'h3E800000, 32'h00000000, 1'b0, 1'b1);
    run(32'hBF000000, 32'h00000000, 1'b0, 1'b1);
    run(32'hBF400000, RNE ? 32'hFFFFFFFF : 32'h0, 1'b0, 1'b1);
    run(32'h3FC00000, RNE ? 32'd2 : 32'd1, 1'b0, 1'b1);
    run(32'h40200000, 32'd2, 1'b0, 1'b1);
    run(32'h4E800001, 32'h40000080, 1'b0, 1'b0);
    run(32'hCE800001, 32'hBFFFFF80, 1'b0, 1'b0);
    run(32'h4EFFFFFF, 32'h7FFFFF80, 1'b0, 1'b0);
    run(32'h4F000000, 32'h7FFFFFFF, 1'b1, 1'b1);
    run(32'hCF000001, 32'h80000000, 1'b1, 1'b1);
    run(32'hFF800000, 32'h80000000, 1'b1, 1'b1);
    run(32'h7F800000, 32'h7FFFFFFF, 1'b1, 1'b1);

    // Backpressure: hold out_ready low for five cycles once the result is up.
    send(32'h40A00000, 1'b0);
    n = 0;
    while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
    chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
    repeat (5) begin @(posedge clk); #1; end
    chk("bp_result_held", result, 32'd5);
    chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_in_ready_after", {31'd0, in_ready}, 32'd1);
    chk("bp_out_valid_after", {31'd0, out_valid}, 32'd0);

    // Reset in the middle of a shift sequence drops the transaction.
    send(32'h40A00000, 1'b1);
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    q.delete();
    cur_seen = 0;
    @(posedge clk); #1; rst = 1'b0;
    repeat (30) begin @(posedge clk); #1; end
    chk("midrst_no_result", {31'd0, out_valid}, 32'd0);
    run(32'h41200000, 32'h0000000A, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
